// File: rtl/stopwatch_ctrl.sv
// Stopwatch button controller: synchronises and debounces three push-buttons,
// cycles the display mode and sequences the stopwatch run/pause/lap/clear FSM.
module stopwatch_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned NUM_MODES       = 4,
  parameter int unsigned STOPWATCH_MODE  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       button_mode,
  input  logic       button_start_stop,
  input  logic       button_reset,
  output logic [1:0] rezhim,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       sw_lap,
  output logic [1:0] sw_state
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]    MODE_LAST = 2'(NUM_MODES - 1);
  localparam logic [1:0]    SW_MODE   = 2'(STOPWATCH_MODE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } state_t;

  // Bit 0 = mode, bit 1 = start/stop, bit 2 = reset/lap.
  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    level;
  logic [2:0]    press;
  logic [CW-1:0] cnt [3];

  assign raw = {button_reset, button_start_stop, button_mode};

  // The counter runs only while the synchronised level disagrees with the
  // accepted one; the last counted cycle both accepts the level and emits the
  // press, so the press register lands 2 + DEBOUNCE_CYCLES cycles after the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i] <= sync2[i];
          press[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  logic mode_press;
  logic sw_enabled;
  logic ss_eff;
  logic rp_eff;

  assign mode_press = press[0];
  assign sw_enabled = (rezhim == SW_MODE);
  assign rp_eff     = press[2] & sw_enabled;
  assign ss_eff     = press[1] & sw_enabled & ~rp_eff;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rezhim <= '0;
    end else if (mode_press) begin
      rezhim <= (rezhim >= MODE_LAST) ? '0 : rezhim + 2'd1;
    end
  end

  state_t state;
  state_t state_next;
  logic   run_next;
  logic   lap_next;
  logic   clear_next;

  // Outputs are registered from the next-state decode so they move together with sw_state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sw_run   <= 1'b0;
      sw_lap   <= 1'b0;
      sw_clear <= 1'b0;
    end else begin
      state    <= state_next;
      sw_run   <= run_next;
      sw_lap   <= lap_next;
      sw_clear <= clear_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (ss_eff) state_next = RUN;
      end
      RUN: begin
        if (rp_eff)      state_next = LAP;
        else if (ss_eff) state_next = PAUSE;
      end
      LAP: begin
        if (rp_eff)      state_next = RUN;
        else if (ss_eff) state_next = PAUSE;
      end
      PAUSE: begin
        if (rp_eff)      state_next = IDLE;
        else if (ss_eff) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    run_next   = (state_next == RUN) || (state_next == LAP);
    lap_next   = (state_next == LAP);
    clear_next = rp_eff && (state_next == IDLE);
  end

  assign sw_state = state;

endmodule
